// File: rtl/mdu_sequencer.sv
// HI/LO owner for the pipeline: sequences multi-cycle MULT/DIV with a fixed-latency
// busy counter, handles MTHI/MTLO directly, and requests D-stage stalls while busy.
module mdu_sequencer #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    input  logic        rd_hi,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hl_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;

    logic        sgn;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;
    logic [63:0] prod_s, prod_u;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of relying on tool-specific overflow behaviour.
    always_comb begin
        sgn    = ~op_q[0];
        a_mag  = (sgn && a_q[31]) ? (~a_q + 32'd1) : a_q;
        b_mag  = (sgn && b_q[31]) ? (~b_q + 32'd1) : b_q;
        q_mag  = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        r_mag  = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        div_q  = (sgn && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
        div_r  = (sgn && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
        prod_s = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            default: begin
                res_hi = div_r;
                res_lo = div_q;
                res_wr = (b_q != 32'd0);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op <= 3'd3) begin
                            op_q  <= op;
                            a_q   <= a;
                            b_q   <= b;
                            cnt   <= (op < OP_DIV) ? MUL_CNT : DIV_CNT;
                            state <= RUN;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                default: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign stall_req = md_use_d & (busy | (start & (op <= 3'd3)));
    assign hl_out    = rd_hi ? hi : lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, MULT/DIV results, MTHI/MTLO,
// stall request, divide corner cases and async reset abort.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        md_use_d, rd_hi;
    logic        busy, stall_req;
    logic [31:0] hl_out, hi, lo;

    int tests = 0;
    int fails = 0;
    int n;
    int nstall;

    mdu_sequencer #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_use_d(md_use_d), .rd_hi(rd_hi), .busy(busy), .stall_req(stall_req),
        .hl_out(hl_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge with the given op/operands.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0; op = 3'd7;
    endtask

    // Counts sampled busy cycles (and stall cycles) until busy drops; bounded.
    task automatic wait_done(output int cyc, output int stc);
        cyc = 0; stc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            if (stall_req) stc++;
            step();
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd7; a = 32'd0; b = 32'd0;
        md_use_d = 1'b0; rd_hi = 1'b0;
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_hl", hl_out, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        reset = 1'b1;
        step();

        // MULT / MULTU
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_done(n, nstall);
        chk("mult_lat", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_done(n, nstall);
        chk("multu_lat", n, 32'd5);
        chk("multu_hi", hi, 32'h2);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        // DIV / DIVU
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(n, nstall);
        chk("div_lat", n, 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        issue(3'd3, 32'd7, 32'd2);
        wait_done(n, nstall);
        chk("divu_lat", n, 32'd10);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        // MTHI / MTLO back to back
        start = 1'b1; op = 3'd4; a = 32'h1234;
        step();
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd5; a = 32'h5678;
        step();
        start = 1'b0; op = 3'd7;
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mt_hi", hi, 32'h1234);
        chk("mt_lo", lo, 32'h5678);
        rd_hi = 1'b1; #1;
        chk("hl_sel_hi", hl_out, 32'h1234);
        rd_hi = 1'b0; #1;
        chk("hl_sel_lo", hl_out, 32'h5678);

        // NOP op ignored
        issue(3'd6, 32'hDEAD, 32'hBEEF);
        chk("nop_busy", {31'd0, busy}, 32'd0);
        chk("nop_hi", hi, 32'h1234);

        // Stall request with md_use_d held
        md_use_d = 1'b1;
        start = 1'b1; op = 3'd0; a = 32'd4; b = 32'd5; #1;
        chk("stall_start", {31'd0, stall_req}, 32'd1);
        step();
        start = 1'b0; op = 3'd7;
        wait_done(n, nstall);
        chk("stall_busy_cnt", nstall, 32'd5);
        chk("stall_drop", {31'd0, stall_req}, 32'd0);
        chk("stall_mult_lo", lo, 32'd20);
        md_use_d = 1'b0;
        start = 1'b1; op = 3'd2; a = 32'd9; b = 32'd3; #1;
        chk("nostall_start", {31'd0, stall_req}, 32'd0);
        step();
        start = 1'b0; op = 3'd7;
        wait_done(n, nstall);
        chk("nostall_cnt", nstall, 32'd0);
        chk("div9_lo", lo, 32'd3);

        // Divide by zero leaves HI/LO untouched
        issue(3'd4, 32'hAA, 32'd0);
        issue(3'd5, 32'hBB, 32'd0);
        issue(3'd2, 32'd100, 32'd0);
        wait_done(n, nstall);
        chk("dz_lat", n, 32'd10);
        chk("dz_hi", hi, 32'hAA);
        chk("dz_lo", lo, 32'hBB);

        // Overflowing signed divide wraps
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, nstall);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'd0);

        // Async reset in the middle of a DIV
        issue(3'd2, 32'd50, 32'd7);
        step();
        step();
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0; #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        step();
        reset = 1'b1;
        step();
        issue(3'd0, 32'd2, 32'd3);
        wait_done(n, nstall);
        chk("post_lat", n, 32'd5);
        chk("post_lo", lo, 32'd6);
        chk("post_hi", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
